// File: rtl/segre_mem_arbiter.sv
// In-order arbiter between the instruction cache, the data cache and a single main-memory port.
// Requests queue in a circular FIFO and are served one at a time. Each response returns to the cache that issued it.
module segre_mem_arbiter #(
    parameter int ADDR_SIZE = 32,
    parameter int BUF_SIZE  = 16,
    parameter int PTR_SIZE  = 4,
    parameter int LINE_BITS = 128
) (
    input  logic                 clk_i,
    input  logic                 rsn_i,
    input  logic                 ic_req_i,
    input  logic [ADDR_SIZE-1:0] ic_addr_i,
    output logic                 ic_gnt_o,
    output logic                 ic_valid_o,
    output logic [LINE_BITS-1:0] ic_line_o,
    input  logic                 dc_req_i,
    input  logic                 dc_rd_i,
    input  logic                 dc_wr_i,
    input  logic [ADDR_SIZE-1:0] dc_addr_i,
    input  logic [LINE_BITS-1:0] dc_line_i,
    output logic                 dc_gnt_o,
    output logic                 dc_valid_o,
    output logic [LINE_BITS-1:0] dc_line_o,
    output logic                 mem_rd_o,
    output logic                 mem_wr_o,
    output logic [ADDR_SIZE-1:0] mem_addr_o,
    output logic [LINE_BITS-1:0] mem_line_o,
    input  logic                 mem_ready_i,
    input  logic [LINE_BITS-1:0] mem_line_i
);

    typedef enum logic {ICACHE = 1'b0, DCACHE = 1'b1} cache_id_t;

    typedef struct packed {
        logic [ADDR_SIZE-1:0] addr;
        logic [LINE_BITS-1:0] line;
        logic                 rd;
        logic                 wr;
        cache_id_t            cache_id;
    } cache_mem_req_t;

    typedef enum logic [1:0] {IDLE, BUSY, RESP} state_t;

    localparam logic [PTR_SIZE:0] FULL = (PTR_SIZE+1)'(BUF_SIZE);

    cache_mem_req_t      fifo_q [BUF_SIZE];
    logic [PTR_SIZE-1:0] head_q, tail_q;
    logic [PTR_SIZE:0]   count_q, count_d;
    state_t              state_q, state_d;
    cache_mem_req_t      head, ic_entry, dc_entry;
    logic                pop;

    assign head = fifo_q[head_q];

    // A dcache entry with both rd and wr set is stored as a write.
    always_comb begin
        dc_entry          = '0;
        dc_entry.addr     = dc_addr_i;
        dc_entry.line     = dc_line_i;
        dc_entry.wr       = dc_wr_i;
        dc_entry.rd       = dc_rd_i & ~dc_wr_i;
        dc_entry.cache_id = DCACHE;
        ic_entry          = '0;
        ic_entry.addr     = ic_addr_i;
        ic_entry.rd       = 1'b1;
        ic_entry.cache_id = ICACHE;
    end

    // The dcache gets the free slot first. The icache is granted only if a second slot remains.
    always_comb begin
        dc_gnt_o = rsn_i && dc_req_i && (count_q < FULL);
        ic_gnt_o = rsn_i && ic_req_i && ((count_q + (PTR_SIZE+1)'(dc_gnt_o)) < FULL);
        count_d  = count_q + (PTR_SIZE+1)'(dc_gnt_o) + (PTR_SIZE+1)'(ic_gnt_o)
                 - (PTR_SIZE+1)'(pop);
    end

    always_ff @(posedge clk_i) begin
        if (dc_gnt_o)
            fifo_q[tail_q] <= dc_entry;
        if (ic_gnt_o)
            fifo_q[dc_gnt_o ? tail_q + PTR_SIZE'(1) : tail_q] <= ic_entry;
    end

    always_ff @(posedge clk_i or negedge rsn_i) begin
        if (!rsn_i) begin
            head_q  <= '0;
            tail_q  <= '0;
            count_q <= '0;
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
            count_q <= count_d;
            tail_q  <= tail_q + PTR_SIZE'(dc_gnt_o) + PTR_SIZE'(ic_gnt_o);
            if (pop)
                head_q <= head_q + PTR_SIZE'(1);
        end
    end

    // Each cache's line output is its own response register. A write completion leaves dc_line_o untouched.
    always_ff @(posedge clk_i or negedge rsn_i) begin
        if (!rsn_i) begin
            ic_line_o <= '0;
            dc_line_o <= '0;
        end else if (state_q == BUSY && mem_ready_i) begin
            if (head.cache_id == ICACHE)
                ic_line_o <= mem_line_i;
            else if (!head.wr)
                dc_line_o <= mem_line_i;
        end
    end

    always_comb begin
        state_d    = state_q;
        pop        = 1'b0;
        mem_rd_o   = 1'b0;
        mem_wr_o   = 1'b0;
        mem_addr_o = '0;
        mem_line_o = '0;
        ic_valid_o = 1'b0;
        dc_valid_o = 1'b0;
        case (state_q)
            IDLE: begin
                if (count_q != '0)
                    state_d = BUSY;
            end
            BUSY: begin
                mem_rd_o   = head.rd;
                mem_wr_o   = head.wr;
                mem_addr_o = head.addr;
                mem_line_o = head.line;
                if (mem_ready_i)
                    state_d = RESP;
            end
            RESP: begin
                ic_valid_o = (head.cache_id == ICACHE);
                dc_valid_o = (head.cache_id == DCACHE);
                pop        = 1'b1;
                state_d    = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

endmodule

// File: tb/tb_segre_mem_arbiter.sv
// Randomized scoreboard bench for segre_mem_arbiter.
// It models grants, memory issue order and timing, and the routing of responses.
module tb_segre_mem_arbiter;
    localparam int AW    = 32;
    localparam int LW    = 128;
    localparam int DEPTH = 16;

    logic          clk = 1'b0;
    logic          rsn_i = 1'b0;
    logic          ic_req_i = 1'b0;
    logic [AW-1:0] ic_addr_i = '0;
    logic          ic_gnt_o, ic_valid_o;
    logic [LW-1:0] ic_line_o;
    logic          dc_req_i = 1'b0, dc_rd_i = 1'b0, dc_wr_i = 1'b0;
    logic [AW-1:0] dc_addr_i = '0;
    logic [LW-1:0] dc_line_i = '0;
    logic          dc_gnt_o, dc_valid_o;
    logic [LW-1:0] dc_line_o;
    logic          mem_rd_o, mem_wr_o;
    logic [AW-1:0] mem_addr_o;
    logic [LW-1:0] mem_line_o;
    logic          mem_ready_i = 1'b0;
    logic [LW-1:0] mem_line_i = '0;

    segre_mem_arbiter dut (
        .clk_i(clk), .rsn_i(rsn_i),
        .ic_req_i(ic_req_i), .ic_addr_i(ic_addr_i), .ic_gnt_o(ic_gnt_o),
        .ic_valid_o(ic_valid_o), .ic_line_o(ic_line_o),
        .dc_req_i(dc_req_i), .dc_rd_i(dc_rd_i), .dc_wr_i(dc_wr_i),
        .dc_addr_i(dc_addr_i), .dc_line_i(dc_line_i), .dc_gnt_o(dc_gnt_o),
        .dc_valid_o(dc_valid_o), .dc_line_o(dc_line_o),
        .mem_rd_o(mem_rd_o), .mem_wr_o(mem_wr_o), .mem_addr_o(mem_addr_o),
        .mem_line_o(mem_line_o), .mem_ready_i(mem_ready_i), .mem_line_i(mem_line_i)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [AW-1:0] addr;
        logic [LW-1:0] line;
        bit            rd;
        bit            wr;
        bit            dc;
        int            cyc;
    } mreq_t;

    typedef struct {
        bit            dc;
        bit            wr;
        logic [LW-1:0] line;
        int            cyc;
    } resp_t;

    mreq_t mem_q[$];
    resp_t resp_q[$];

    int cyc = 0;
    int cnt = 0;
    int n_cmp = 0;
    int n_bad = 0;
    int prev_ready = -100;
    int ic_rate = 0, dc_rate = 0, fixed_delay = -1;
    bit mem_auto = 1'b1, pattern_data = 1'b0, force_ready = 1'b0, drv_kill = 1'b0;
    bit ic_took = 1'b0, dc_took = 1'b0;
    bit inj_ic = 1'b0, inj_dc = 1'b0, inj_dc_wr = 1'b0;
    logic [AW-1:0] inj_ic_addr = '0, inj_dc_addr = '0;
    logic [LW-1:0] inj_dc_line = '0;
    logic [LW-1:0] last_dc = '0;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string name, input logic [LW-1:0] act, input logic [LW-1:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %h expected %h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    task automatic wait_idle(input int budget);
        int n = 0;
        bit idle = 1'b0;
        while (!idle && n < budget) begin
            @(negedge clk); #2;
            n++;
            idle = (cnt == 0) && (mem_q.size() == 0) && (resp_q.size() == 0) &&
                   !ic_req_i && !dc_req_i && !inj_ic && !inj_dc;
        end
        chk("idle_reached", LW'(idle), LW'(1'b1));
    endtask

    // Request driver: holds each request until the model says it was granted.
    initial begin
        forever begin
            @(posedge clk); #1;
            if (drv_kill) begin
                ic_req_i = 1'b0;
                dc_req_i = 1'b0;
            end else begin
                if (ic_req_i && ic_took) ic_req_i = 1'b0;
                if (dc_req_i && dc_took) dc_req_i = 1'b0;
                if (!ic_req_i && (inj_ic || ($urandom_range(0, 99) < ic_rate))) begin
                    ic_req_i  = 1'b1;
                    ic_addr_i = inj_ic ? inj_ic_addr : ($urandom & 32'hFFFF_FFF0);
                    inj_ic    = 1'b0;
                end
                if (!dc_req_i && (inj_dc || ($urandom_range(0, 99) < dc_rate))) begin
                    dc_req_i = 1'b1;
                    if (inj_dc) begin
                        dc_addr_i = inj_dc_addr;
                        dc_line_i = inj_dc_line;
                        dc_wr_i   = inj_dc_wr;
                    end else begin
                        dc_addr_i = $urandom & 32'hFFFF_FFF0;
                        dc_line_i = {$urandom, $urandom, $urandom, $urandom};
                        dc_wr_i   = ($urandom_range(0, 1) == 1);
                    end
                    dc_rd_i = !dc_wr_i;
                    inj_dc  = 1'b0;
                end
            end
        end
    end

    // Grant model. Free space is the depth minus the requests that are granted and not yet answered.
    initial begin
        bit e_dc, e_ic;
        forever begin
            @(negedge clk);
            if (!rsn_i) begin
                ic_took = 1'b0;
                dc_took = 1'b0;
            end else begin
                if (dc_req_i) assert (!(dc_rd_i && dc_wr_i)) else $error("dcache read and write both set");
                e_dc = dc_req_i && (cnt < DEPTH);
                e_ic = ic_req_i && ((cnt + int'(e_dc)) < DEPTH);
                chk("dc_gnt", LW'(dc_gnt_o), LW'(e_dc));
                chk("ic_gnt", LW'(ic_gnt_o), LW'(e_ic));
                if (e_dc) mem_q.push_back('{dc_addr_i, dc_line_i, !dc_wr_i, dc_wr_i, 1'b1, cyc});
                if (e_ic) mem_q.push_back('{ic_addr_i, LW'(0), 1'b1, 1'b0, 1'b0, cyc});
                cnt    += int'(e_dc) + int'(e_ic);
                dc_took = e_dc;
                ic_took = e_ic;
            end
        end
    end

    // Memory model: checks issue order and timing, then answers after a short delay.
    initial begin
        mreq_t         m;
        int            d, exp_start;
        bit            have;
        logic [LW-1:0] data;
        forever begin
            @(negedge clk);
            if (force_ready) begin
                mem_ready_i = 1'b1;
                mem_line_i  = {$urandom, $urandom, $urandom, $urandom};
                @(posedge clk); #1;
                mem_ready_i = 1'b0;
                force_ready = 1'b0;
            end else if (rsn_i && (mem_rd_o || mem_wr_o)) begin
                have = (mem_q.size() != 0);
                chk("mem_req_expected", LW'(have), LW'(1'b1));
                if (have) begin
                    m = mem_q.pop_front();
                    chk("mem_addr", LW'(mem_addr_o), LW'(m.addr));
                    chk("mem_rd", LW'(mem_rd_o), LW'(m.rd));
                    chk("mem_wr", LW'(mem_wr_o), LW'(m.wr));
                    if (m.wr) chk("mem_wdata", mem_line_o, m.line);
                    exp_start = (m.cyc + 2 > prev_ready + 3) ? m.cyc + 2 : prev_ready + 3;
                    chk("issue_cycle", LW'(cyc), LW'(exp_start));
                end
                while (!mem_auto && rsn_i) @(negedge clk);
                if (rsn_i) begin
                    d = (fixed_delay >= 0) ? fixed_delay : int'($urandom_range(0, 3));
                    repeat (d) @(negedge clk);
                    if (have) chk("mem_addr_held", LW'(mem_addr_o), LW'(m.addr));
                    data        = pattern_data ? {16{8'hA5}} : {$urandom, $urandom, $urandom, $urandom};
                    mem_ready_i = 1'b1;
                    mem_line_i  = data;
                    prev_ready  = cyc;
                    if (have) resp_q.push_back('{m.dc, m.wr, m.wr ? LW'(0) : data, cyc + 1});
                    @(posedge clk); #1;
                    mem_ready_i = 1'b0;
                end
            end
        end
    end

    // Response monitor.
    initial begin
        resp_t r;
        forever begin
            @(negedge clk); #1;
            if (ic_valid_o || dc_valid_o) begin
                chk("single_valid", LW'(ic_valid_o && dc_valid_o), LW'(1'b0));
                chk("resp_pending", LW'(resp_q.size() != 0), LW'(1'b1));
                if (resp_q.size() != 0) begin
                    r = resp_q.pop_front();
                    chk("valid_cycle", LW'(cyc), LW'(r.cyc));
                    chk("resp_to_dcache", LW'(dc_valid_o), LW'(r.dc));
                    if (!r.dc)
                        chk("ic_line", ic_line_o, r.line);
                    else if (r.wr)
                        chk("dc_line_kept", dc_line_o, last_dc);
                    else begin
                        chk("dc_line", dc_line_o, r.line);
                        last_dc = r.line;
                    end
                    cnt--;
                end
            end
        end
    end

    initial begin
        #300000;
        $display("FAIL watchdog: simulation time limit reached, got %0d cycles expected completion", cyc);
        $fatal(1, "timeout");
    end

    initial begin
        int n;
        repeat (3) @(posedge clk);
        #1;
        chk("rst_mem_ctrl", LW'({mem_rd_o, mem_wr_o, ic_valid_o, dc_valid_o}), LW'(0));
        chk("rst_mem_addr", LW'(mem_addr_o), LW'(0));
        chk("rst_ic_line", ic_line_o, LW'(0));
        chk("rst_dc_line", dc_line_o, LW'(0));
        rsn_i = 1'b1;

        // Single icache fill, memory answers three cycles after the request with 0xA5 bytes.
        fixed_delay  = 3;
        pattern_data = 1'b1;
        inj_ic_addr  = 32'h0000_1040;
        inj_ic       = 1'b1;
        wait_idle(100);
        chk("ic_line_a5", ic_line_o, {16{8'hA5}});
        pattern_data = 1'b0;
        fixed_delay  = -1;

        // Simultaneous dcache write-back and icache fill.
        inj_dc_addr = 32'h0000_2000;
        inj_dc_line = {4{32'h1234_5678}};
        inj_dc_wr   = 1'b1;
        inj_ic_addr = 32'h0000_3000;
        inj_dc      = 1'b1;
        inj_ic      = 1'b1;
        wait_idle(100);

        // Fill with memory stalled, then add icache pressure, then drain.
        mem_auto = 1'b0;
        dc_rate  = 100;
        repeat (40) @(negedge clk);
        ic_rate = 100;
        repeat (5) @(negedge clk);
        mem_auto = 1'b1;
        repeat (60) @(negedge clk);
        ic_rate = 0;
        dc_rate = 0;
        wait_idle(1000);

        // Random traffic.
        ic_rate = 30;
        dc_rate = 30;
        repeat (800) @(negedge clk);
        ic_rate = 0;
        dc_rate = 0;
        wait_idle(1000);

        // Stray mem_ready_i while idle must be ignored.
        force_ready = 1'b1;
        n = 0;
        while (force_ready && n < 20) begin @(negedge clk); n++; end
        repeat (4) @(negedge clk);
        chk("idle_stray_ready", LW'({mem_rd_o, mem_wr_o}), LW'(0));
        inj_ic_addr = 32'h0000_4440;
        inj_ic      = 1'b1;
        wait_idle(100);

        // Asynchronous reset while a read is outstanding.
        mem_auto    = 1'b0;
        inj_ic_addr = 32'h0000_5000;
        inj_ic      = 1'b1;
        n = 0;
        while (!mem_rd_o && n < 20) begin @(negedge clk); n++; end
        chk("busy_reached", LW'(mem_rd_o), LW'(1'b1));
        @(negedge clk); #2;
        rsn_i    = 1'b0;
        drv_kill = 1'b1;
        #1;
        chk("async_rst_mem_rd", LW'(mem_rd_o), LW'(1'b0));
        chk("async_rst_mem_addr", LW'(mem_addr_o), LW'(0));
        chk("async_rst_lines", {ic_line_o[63:0], dc_line_o[63:0]}, LW'(0));
        mem_q.delete();
        resp_q.delete();
        cnt        = 0;
        last_dc    = '0;
        prev_ready = -100;
        repeat (2) @(posedge clk);
        #1;
        rsn_i       = 1'b1;
        mem_auto    = 1'b1;
        force_ready = 1'b1;
        n = 0;
        while (force_ready && n < 20) begin @(negedge clk); n++; end
        repeat (5) @(negedge clk);
        chk("post_rst_no_issue", LW'({mem_rd_o, mem_wr_o}), LW'(0));
        drv_kill    = 1'b0;
        inj_dc_addr = 32'h0000_6000;
        inj_dc_wr   = 1'b0;
        inj_dc      = 1'b1;
        wait_idle(100);

        chk("final_queues_empty", LW'(mem_q.size() + resp_q.size()), LW'(0));
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
